tinker_mem_responder: RTL and testbench
=======================================

Name: tinker_mem_responder

Overview:
Multi-cycle memory responder serving the tinker core's two request streams: 32-bit instruction fetch and 64-bit data load/store. It owns a byte-addressed little-endian array with one port, and accepts one transaction at a time through valid/ready handshakes. A configurable access latency models a slow memory so the core can be made stall-tolerant. At most one transaction is outstanding across both channels.

Parameters:
MEM_SIZE, 524288, array size in bytes; legal addresses are 0..MEM_SIZE-1
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15
CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > LATENCY

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
f_req_valid  in  1  fetch request valid
f_req_ready  out  1  fetch request accepted this cycle when high with f_req_valid
f_req_addr  in  32  fetch byte address
f_rsp_valid  out  1  fetch response valid
f_rsp_ready  in  1  fetch response consumed
f_rsp_data  out  32  instruction, little-endian: {b[a+3],b[a+2],b[a+1],b[a]}
f_rsp_err  out  1  fetch address out of range
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle when high with d_req_valid
d_req_addr  in  32  data byte address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  64  store data
d_rsp_valid  out  1  data response valid (loads and stores)
d_rsp_ready  in  1  data response consumed
d_rsp_rdata  out  64  load data, little-endian {b[a+7],...,b[a]}; 0 for stores and errors
d_rsp_err  out  1  data address out of range

Behaviour:
- Reset (async): state IDLE, counter 0, latched request cleared. All outputs are 0: both ready signals, both rsp_valid, both rsp data buses and both err flags. Array contents are not cleared.
- FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - d_req_ready = 1.
  - f_req_ready = !d_req_valid. Data has fixed priority over fetch.
  - On a handshake: latch the channel, addr, we and wdata; load counter with LATENCY-1; go to WAIT.
  - When both channels are valid, data is accepted and fetch waits with f_req_ready=0.
- WAIT:
  - Both ready signals are 0.
  - Counter decrements each edge.
  - At the edge where counter==0:
    - perform the array access;
    - register the response data and err;
    - assert the channel's rsp_valid;
    - go to RESP.
  - Net latency: request accepted at edge k, rsp_valid high after edge k+LATENCY.
- RESP:
  - The selected rsp_valid, data and err are held stable until that channel's rsp_ready is 1 at an edge.
  - On that edge: rsp_valid, data and err return to 0 and the FSM goes to IDLE.
  - A new request can be accepted no earlier than the cycle after the response is consumed. Throughput is at most 1 transaction per LATENCY+2 cycles.
- Stores: all 8 bytes are written little-endian at the access edge, b[a] = wdata[7:0] ... b[a+7] = wdata[63:56]. The response carries rdata=0.
- Range check, 33-bit arithmetic with no wrap:
  - the range is addr+3 for fetch and addr+7 for data;
  - err=1 when this value is >= MEM_SIZE;
  - on err, no bytes are written and the response data is 0;
  - an err response still completes the handshake normally.
- Unaligned addresses are legal. There is no alignment check.
- A store followed by a load of the same address returns the new data, because the accesses are serialized.
- Request inputs are sampled only at the accepting edge. Changes to them during WAIT or RESP are ignored.
- Reset asserted in WAIT: the transaction is dropped and no write occurs. Reset asserted in RESP: the response is lost. In both cases memory keeps any write already committed.
- rsp_valid is never asserted on the non-selected channel.

Test Plan:
- LATENCY=2, store addr 0x100, wdata 0x1122334455667788, then load 0x100 -> store response has rdata=0, err=0. Bytes b[0x100]=0x88 ... b[0x107]=0x11. Load returns 0x1122334455667788, with d_rsp_valid rising exactly 2 edges after acceptance.
- Preload b[0x2000..0x2003]=0x13,0x00,0x40,0xC8 and fetch 0x2000 -> f_rsp_data=0xC8400013, err=0.
- f_req_valid and d_req_valid asserted in the same IDLE cycle -> d_req_ready=1 and f_req_ready=0. Data completes first; fetch is accepted the cycle after d_rsp is consumed.
- Hold d_rsp_ready=0 for 5 cycles after a load -> d_rsp_valid and d_rsp_rdata stay stable, and both req_ready stay 0. Raising d_rsp_ready gives return to IDLE on that edge.
- Store at addr MEM_SIZE-4 with MEM_SIZE=524288 -> d_rsp_err=1 and no bytes at MEM_SIZE-4..MEM_SIZE-1 change. Fetch at MEM_SIZE-4 -> err=0. Fetch at 0xFFFFFFFE -> err=1 with no wrap.
- Assert reset for 1 cycle during WAIT of a store to 0x200 -> the store is not committed (b[0x200] unchanged), all outputs are 0, and the FSM is IDLE with d_req_ready=1 after reset is released.

Source files
------------

// File: rtl/tinker_mem_responder_if.sv
// Request/response bus between the tinker core and its memory responder.
// Two channels share the bus:
//   f_* : 32-bit instruction fetch (request addr, response data/err)
//   d_* : 64-bit data load/store (request addr/we/wdata, response rdata/err)
// Modports:
//   master : the core side (drives requests, consumes responses)
//   slave  : the responder side (accepts requests, produces responses)
interface tinker_mem_responder_if;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_rsp_valid;
  logic        f_rsp_ready;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [63:0] d_rsp_rdata;
  logic        d_rsp_err;

  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_rsp_ready,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_rsp_ready,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );
endinterface

// File: rtl/tinker_mem_responder.sv
// Multi-cycle memory responder for the tinker core.
// Serves one transaction at a time from either the fetch or the data channel
// out of a byte-addressed little-endian array, with a fixed access latency.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : tinker_mem_responder_if.slave (fetch and data request/response)
// Parameters:
//   MEM_SIZE : array size in bytes
//   LATENCY  : cycles from request acceptance to response valid (1..15)
//   CNT_W    : latency counter width, 2**CNT_W > LATENCY
module tinker_mem_responder #(
  parameter int unsigned MEM_SIZE = 524288,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned CNT_W    = 4
) (
  input logic                   clk,
  input logic                   reset,
  tinker_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              ch_d_r;      // 1 = data channel owns the transaction
  logic [31:0]       addr_r;
  logic              we_r;
  logic [63:0]       wdata_r;
  logic [7:0]        mem_r [MEM_SIZE];

  logic              accept_d_s;
  logic              accept_f_s;
  logic              access_s;
  logic              consume_s;
  logic              err_s;
  logic              mem_we_s;
  logic [AW-1:0]     idx_s;
  logic [63:0]       rd_s;

  // Last touched byte computed in 33 bits so addresses near 2^32 cannot wrap
  // back into range.
  function automatic logic out_of_range(input logic [31:0] a, input logic is_data);
    logic [32:0] last;
    last = {1'b0, a} + (is_data ? 33'd7 : 33'd3);
    return (last >= 33'(MEM_SIZE));
  endfunction

  assign err_s    = out_of_range(addr_r, ch_d_r);
  assign idx_s    = addr_r[AW-1:0];
  assign mem_we_s = access_s & ch_d_r & we_r & ~err_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = (accept_d_s | accept_f_s) ? WAIT : IDLE;
      WAIT:    state_nxt_s = access_s ? RESP : WAIT;
      RESP:    state_nxt_s = consume_s ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs and per-state strobes. Ready is held low while reset
  // is asserted so every output reads 0 during reset; data beats fetch.
  always_comb begin
    bus.d_req_ready = 1'b0;
    bus.f_req_ready = 1'b0;
    accept_d_s      = 1'b0;
    accept_f_s      = 1'b0;
    access_s        = 1'b0;
    consume_s       = 1'b0;
    case (state_r)
      IDLE: begin
        bus.d_req_ready = ~reset;
        bus.f_req_ready = ~reset & ~bus.d_req_valid;
        accept_d_s      = bus.d_req_valid;
        accept_f_s      = bus.f_req_valid & ~bus.d_req_valid;
      end
      WAIT:    access_s  = (cnt_r == {CNT_W{1'b0}});
      RESP:    consume_s = ch_d_r ? bus.d_rsp_ready : bus.f_rsp_ready;
      default: consume_s = 1'b0;
    endcase
  end

  // Request latch and latency counter; inputs are only sampled on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      ch_d_r  <= 1'b0;
      addr_r  <= 32'd0;
      we_r    <= 1'b0;
      wdata_r <= 64'd0;
    end else if (accept_d_s | accept_f_s) begin
      cnt_r   <= CNT_W'(LATENCY - 1);
      ch_d_r  <= accept_d_s;
      addr_r  <= accept_d_s ? bus.d_req_addr : bus.f_req_addr;
      we_r    <= accept_d_s & bus.d_req_we;
      wdata_r <= accept_d_s ? bus.d_req_wdata : 64'd0;
    end else if ((state_r == WAIT) && !access_s) begin
      cnt_r   <= cnt_r - CNT_W'(1);
    end
  end

  // Array read: up to 8 little-endian bytes starting at the latched address.
  always_comb begin
    rd_s = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_s[8*i +: 8] = mem_r[idx_s + AW'(i)];
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 8; i++) begin
        mem_r[idx_s + AW'(i)] <= wdata_r[8*i +: 8];
      end
    end
  end

  // Registered responses: loaded on the access edge, held until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.f_rsp_valid <= 1'b0;
      bus.f_rsp_data  <= 32'd0;
      bus.f_rsp_err   <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_rdata <= 64'd0;
      bus.d_rsp_err   <= 1'b0;
    end else if (access_s) begin
      if (ch_d_r) begin
        bus.d_rsp_valid <= 1'b1;
        bus.d_rsp_rdata <= (err_s | we_r) ? 64'd0 : rd_s;
        bus.d_rsp_err   <= err_s;
      end else begin
        bus.f_rsp_valid <= 1'b1;
        bus.f_rsp_data  <= err_s ? 32'd0 : rd_s[31:0];
        bus.f_rsp_err   <= err_s;
      end
    end else if (consume_s) begin
      bus.f_rsp_valid <= 1'b0;
      bus.f_rsp_data  <= 32'd0;
      bus.f_rsp_err   <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_rdata <= 64'd0;
      bus.d_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Self-checking bench for tinker_mem_responder: directed scenarios plus a
// randomized mix of loads, stores and fetches checked against a byte-level
// memory model held in an associative array.
module tb_tinker_mem_responder;
  localparam int unsigned MEM_SIZE = 524288;
  localparam int unsigned LATENCY  = 2;
  localparam int unsigned CNT_W    = 4;
  localparam int          BOUND    = 40;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [7:0] model [int unsigned];

  tinker_mem_responder_if bus();

  tinker_mem_responder #(
    .MEM_SIZE(MEM_SIZE),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit m_err(input logic [31:0] a, input bit is_d);
    longint last;
    last = longint'({32'd0, a}) + (is_d ? 64'sd7 : 64'sd3);
    return last >= longint'(MEM_SIZE);
  endfunction

  function automatic logic [63:0] m_expect(input bit is_d, input logic [31:0] a, input bit we);
    logic [63:0] r;
    r = 64'd0;
    if (!m_err(a, is_d) && !(is_d && we)) begin
      for (int i = 0; i < (is_d ? 8 : 4); i++) begin
        r[8*i +: 8] = model.exists(a + 32'(i)) ? model[a + 32'(i)] : 8'h00;
      end
    end
    return r;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [63:0] w);
    if (!m_err(a, 1'b1)) begin
      for (int i = 0; i < 8; i++) model[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // ---------------- bus drivers (no checking) ----------------
  task automatic send_req(input bit is_d, input logic [31:0] a, input bit we,
                          input logic [63:0] w, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    if (is_d) begin
      bus.d_req_valid = 1'b1; bus.d_req_addr = a; bus.d_req_we = we; bus.d_req_wdata = w;
    end else begin
      bus.f_req_valid = 1'b1; bus.f_req_addr = a;
    end
    #1;
    while (!(is_d ? bus.d_req_ready : bus.f_req_ready) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      to = 1'b1;
    end else begin
      @(posedge clk);
      #1;
    end
    bus.d_req_valid = 1'b0;
    bus.f_req_valid = 1'b0;
    // Scramble request fields: the DUT must have sampled them already.
    bus.d_req_addr  = $urandom;
    bus.d_req_we    = 1'($urandom_range(0, 1));
    bus.d_req_wdata = {$urandom, $urandom};
    bus.f_req_addr  = $urandom;
  endtask

  task automatic wait_rsp(input bit is_d, output logic [63:0] data, output logic err,
                          output int lat, output bit other, output bit to);
    int n;
    n = 0; other = 1'b0; to = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (is_d ? bus.f_rsp_valid : bus.d_rsp_valid) other = 1'b1;
    end while (!(is_d ? bus.d_rsp_valid : bus.f_rsp_valid) && n < BOUND);
    to   = !(is_d ? bus.d_rsp_valid : bus.f_rsp_valid);
    lat  = n;
    data = is_d ? bus.d_rsp_rdata : {32'd0, bus.f_rsp_data};
    err  = is_d ? bus.d_rsp_err : bus.f_rsp_err;
  endtask

  task automatic consume(input bit is_d);
    if (is_d) bus.d_rsp_ready = 1'b1; else bus.f_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.d_rsp_ready = 1'b0;
    bus.f_rsp_ready = 1'b0;
  endtask

  task automatic txn(input bit is_d, input logic [31:0] a, input bit we, input logic [63:0] w,
                     output logic [63:0] data, output logic err, output int lat,
                     output bit other, output bit to);
    data = 64'd0; err = 1'b0; lat = 0; other = 1'b0;
    send_req(is_d, a, we, w, to);
    if (!to) begin
      wait_rsp(is_d, data, err, lat, other, to);
      if (!to) consume(is_d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.d_req_valid = 1'b1; bus.f_req_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.d_req_ready, bus.f_req_ready, bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rsp_err,
         bus.d_rsp_err, bus.f_rsp_data, bus.d_rsp_rdata} !== {102{1'b0}})
      $display("FAIL reset_outputs: got rdy=%b/%b vld=%b/%b, want all 0",
               bus.d_req_ready, bus.f_req_ready, bus.d_rsp_valid, bus.f_rsp_valid);
    else pass_cnt++;
    bus.d_req_valid = 1'b0; bus.f_req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({bus.d_req_ready, bus.f_req_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b%b, want 11", bus.d_req_ready, bus.f_req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    bit          isd [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit          we  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad  [4] = '{32'h100, 32'h100, 32'h100, 32'h104};
    logic [63:0] ex  [4] = '{64'd0, 64'h1122334455667788, 64'h55667788, 64'h11223344};
    logic [63:0] d; logic e; int l; bit o, t;
    for (int i = 0; i < 4; i++) begin
      txn(isd[i], ad[i], we[i], 64'h1122334455667788, d, e, l, o, t);
      if (isd[i] && we[i]) m_store(ad[i], 64'h1122334455667788);
      total_cnt++;
      if (t || l != LATENCY || o)
        $display("FAIL store_load_timing[%0d]: got to=%0b lat=%0d other=%0b, want 0/%0d/0", i, t, l, o, LATENCY);
      else pass_cnt++;
      total_cnt++;
      if ({e, d} !== {1'b0, ex[i]})
        $display("FAIL store_load_data[%0d]: got err=%0b data=%h, want err=0 data=%h", i, e, d, ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fetch();
    logic [63:0] d; logic e; int l; bit o, t;
    txn(1'b1, 32'h2000, 1'b1, 64'h00000000C8400013, d, e, l, o, t);
    m_store(32'h2000, 64'h00000000C8400013);
    txn(1'b0, 32'h2000, 1'b0, 64'd0, d, e, l, o, t);
    total_cnt++;
    if (t || {e, d} !== {1'b0, 64'h00000000C8400013})
      $display("FAIL fetch_data: got to=%0b err=%0b data=%h, want err=0 data=c8400013", t, e, d);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [63:0] d; logic e; int l; bit o, t;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h100; bus.d_req_we = 1'b0;
    bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h2000;
    #1;
    total_cnt++;
    if ({bus.d_req_ready, bus.f_req_ready} !== 2'b10)
      $display("FAIL priority_ready: got d=%b f=%b, want d=1 f=0", bus.d_req_ready, bus.f_req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
    wait_rsp(1'b1, d, e, l, o, t);
    total_cnt++;
    if (t || o || bus.f_req_ready !== 1'b0 || d !== 64'h1122334455667788)
      $display("FAIL priority_data_first: got to=%0b other=%0b f_rdy=%b data=%h, want 0/0/0/1122334455667788",
               t, o, bus.f_req_ready, d);
    else pass_cnt++;
    consume(1'b1);
    total_cnt++;
    if (bus.f_req_ready !== 1'b1)
      $display("FAIL priority_fetch_next: got f_req_ready=%b, want 1", bus.f_req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    bus.f_req_valid = 1'b0;
    wait_rsp(1'b0, d, e, l, o, t);
    total_cnt++;
    if (t || o || l != LATENCY || {e, d} !== {1'b0, 64'h00000000C8400013})
      $display("FAIL priority_fetch_rsp: got to=%0b other=%0b lat=%0d data=%h, want 0/0/%0d/c8400013",
               t, o, l, d, LATENCY);
    else pass_cnt++;
    consume(1'b0);
  endtask

  task automatic test_stall();
    logic [63:0] d; logic e; int l; bit o, t;
    send_req(1'b1, 32'h100, 1'b0, 64'd0, t);
    if (!t) wait_rsp(1'b1, d, e, l, o, t);
    total_cnt++;
    if (t) $display("FAIL stall_timeout: got timeout, want response");
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({bus.d_rsp_valid, bus.d_req_ready, bus.f_req_ready} !== 3'b100 ||
          bus.d_rsp_rdata !== 64'h1122334455667788)
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b%b data=%h, want vld=1 rdy=00 data=1122334455667788",
                 i, bus.d_rsp_valid, bus.d_req_ready, bus.f_req_ready, bus.d_rsp_rdata);
      else pass_cnt++;
    end
    consume(1'b1);
    total_cnt++;
    if ({bus.d_rsp_valid, bus.d_req_ready} !== 2'b01 || bus.d_rsp_rdata !== 64'd0)
      $display("FAIL stall_release: got vld=%b rdy=%b data=%h, want vld=0 rdy=1 data=0",
               bus.d_rsp_valid, bus.d_req_ready, bus.d_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_bounds();
    bit          isd [6];
    bit          we  [6];
    logic [31:0] ad  [6];
    logic [63:0] w, d, ex;
    logic e, ee; int l; bit o, t;
    w = {$urandom, $urandom};
    isd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    we  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ad  = '{MEM_SIZE - 8, MEM_SIZE - 4, MEM_SIZE - 4, 32'hFFFFFFFE, MEM_SIZE - 7, MEM_SIZE - 3};
    for (int i = 0; i < 6; i++) begin
      ee = m_err(ad[i], isd[i]);
      ex = m_expect(isd[i], ad[i], we[i]);
      txn(isd[i], ad[i], we[i], w, d, e, l, o, t);
      if (isd[i] && we[i]) m_store(ad[i], w);
      total_cnt++;
      if (t || o || {e, d} !== {ee, ex})
        $display("FAIL bounds[%0d] addr=%h: got to=%0b other=%0b err=%0b data=%h, want err=%0b data=%h",
                 i, ad[i], t, o, e, d, ee, ex);
      else pass_cnt++;
    end
    // Explicit spot checks independent of the model.
    txn(1'b0, MEM_SIZE - 4, 1'b0, 64'd0, d, e, l, o, t);
    total_cnt++;
    if (t || {e, d} !== {1'b0, 32'd0, w[63:32]})
      $display("FAIL bounds_no_write: got err=%0b data=%h, want err=0 data=%h", e, d, w[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] d; logic e; int l; bit o, t;
    txn(1'b1, 32'h200, 1'b1, 64'hA5A5_0102_0304_5A5A, d, e, l, o, t);
    m_store(32'h200, 64'hA5A5_0102_0304_5A5A);
    send_req(1'b1, 32'h200, 1'b1, 64'hFFEE_DDCC_BBAA_9988, t);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (t || {bus.d_req_ready, bus.f_req_ready, bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rsp_err,
              bus.d_rsp_err, bus.f_rsp_data, bus.d_rsp_rdata} !== {102{1'b0}})
      $display("FAIL wait_reset_outputs: got to=%0b rdy=%b vld=%b, want all 0", t, bus.d_req_ready, bus.d_rsp_valid);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (bus.d_req_ready !== 1'b1)
      $display("FAIL wait_reset_idle: got d_req_ready=%b, want 1", bus.d_req_ready);
    else pass_cnt++;
    txn(1'b1, 32'h200, 1'b0, 64'd0, d, e, l, o, t);
    total_cnt++;
    if (t || {e, d} !== {1'b0, m_expect(1'b1, 32'h200, 1'b0)})
      $display("FAIL wait_reset_no_commit: got err=%0b data=%h, want err=0 data=%h",
               e, d, m_expect(1'b1, 32'h200, 1'b0));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] w, d, ex;
    logic [31:0] a;
    logic e, ee; int l, kind; bit o, t, isd, we;
    for (int i = 0; i < 34; i++) begin
      w = {$urandom, $urandom};
      txn(1'b1, 32'h3000 + 32'(8 * i), 1'b1, w, d, e, l, o, t);
      m_store(32'h3000 + 32'(8 * i), w);
    end
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      isd  = (kind != 2) ? (kind == 3 ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      we   = isd && (kind == 0 || (kind == 3 && $urandom_range(0, 1) == 1));
      a    = (kind == 3) ? (($urandom_range(0, 1) == 1) ? MEM_SIZE - 32'($urandom_range(1, 8))
                                                        : 32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                         : 32'h3000 + 32'($urandom_range(0, 256));
      w    = {$urandom, $urandom};
      ee   = m_err(a, isd);
      ex   = m_expect(isd, a, we);
      txn(isd, a, we, w, d, e, l, o, t);
      if (isd && we) m_store(a, w);
      total_cnt++;
      if (t || o || l != LATENCY)
        $display("FAIL rand_timing[%0d]: got to=%0b other=%0b lat=%0d, want 0/0/%0d", i, t, o, l, LATENCY);
      else pass_cnt++;
      total_cnt++;
      if ({e, d} !== {ee, ex})
        $display("FAIL rand_data[%0d] d=%0b we=%0b addr=%h: got err=%0b data=%h, want err=%0b data=%h",
                 i, isd, we, a, e, d, ee, ex);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.f_req_valid = 1'b0; bus.f_req_addr = 32'd0; bus.f_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b0; bus.d_req_addr = 32'd0; bus.d_req_we = 1'b0;
    bus.d_req_wdata = 64'd0; bus.d_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_fetch();
    test_priority();
    test_stall();
    test_bounds();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
